// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: I/O map, filler value, decode and read-return states.
package dmem_pkg;

  localparam logic [15:0] ADDR_KEY  = 16'hFFF0;
  localparam logic [15:0] ADDR_SW   = 16'hFFF2;
  localparam logic [15:0] ADDR_HEX  = 16'hFFF8;
  localparam logic [15:0] ADDR_LEDR = 16'hFFFA;
  localparam logic [15:0] ADDR_LEDG = 16'hFFFC;

  // Returned for reads of addresses that are neither RAM nor a known I/O register.
  localparam logic [15:0] DEAD_VAL  = 16'hDEAD;

  // Read-return FSM: which requester receives RVALID in the current cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DMA = 2'd2
  } rd_state_e;

  // Target selected by a byte address.
  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_KEY,
    SEL_SW,
    SEL_HEX,
    SEL_LEDR,
    SEL_LEDG,
    SEL_NONE
  } addr_sel_e;

  // The low 8 KB is RAM; the I/O registers sit at fixed addresses near the top.
  function automatic addr_sel_e decode_addr(input logic [15:0] addr);
    addr_sel_e sel;
    sel = SEL_NONE;
    if (addr[15:13] == 3'b000) begin
      sel = SEL_RAM;
    end else begin
      case (addr)
        ADDR_KEY:  sel = SEL_KEY;
        ADDR_SW:   sel = SEL_SW;
        ADDR_HEX:  sel = SEL_HEX;
        ADDR_LEDR: sel = SEL_LEDR;
        ADDR_LEDG: sel = SEL_LEDG;
        default:   sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/dmem_io_regs.sv
// Address decode of the granted transaction, HEX/LEDR/LEDG output registers and I/O readback mux.
module dmem_io_regs
  import dmem_pkg::*;
#(
  parameter int DBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_i,
  input  logic             we_i,
  input  logic [DBITS-1:0] addr_i,
  input  logic [DBITS-1:0] wdata_i,
  input  logic [3:0]       key_i,
  input  logic [9:0]       sw_i,
  output logic             is_ram_o,
  output logic [DBITS-1:0] rdata_o,
  output logic [DBITS-1:0] hex_o,
  output logic [9:0]       ledr_o,
  output logic [7:0]       ledg_o
);

  addr_sel_e        sel;
  logic [DBITS-1:0] hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [7:0]       ledg_q, ledg_d;

  // Decode the address currently presented by the granted requester.
  always_comb begin
    sel      = decode_addr(addr_i);
    is_ram_o = (sel == SEL_RAM);
  end

  // Read value for non-RAM addresses; unknown addresses read as DEAD_VAL.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rdata_o = DBITS'(DEAD_VAL);
    case (sel)
      SEL_KEY:  rdata_o = DBITS'({12'b0, key_i});
      SEL_SW:   rdata_o = DBITS'({6'b0, sw_i});
      SEL_HEX:  rdata_o = hex_q;
      SEL_LEDR: rdata_o = DBITS'({6'b0, ledr_q});
      SEL_LEDG: rdata_o = DBITS'({8'b0, ledg_q});
      default:  rdata_o = DBITS'(DEAD_VAL);
    endcase
  end

  // Output-register updates; writes to KEY/SW or unknown addresses are dropped.
  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    if (acc_i && we_i) begin
      case (sel)
        SEL_HEX:  hex_d  = wdata_i;
        SEL_LEDR: ledr_d = wdata_i[9:0];
        SEL_LEDG: ledg_d = wdata_i[7:0];
        default:  ;
      endcase
    end
  end

  // Output registers; they clear as soon as reset is asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      hex_q  <= '0;
      ledr_q <= '0;
      ledg_q <= '0;
    end else begin
      hex_q  <= hex_d;
      ledr_q <= ledr_d;
      ledg_q <= ledg_d;
    end
  end

  assign hex_o  = hex_q;
  assign ledr_o = ledr_q;
  assign ledg_o = ledg_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shared data-memory port: CPU/DMA arbitration with a DMA starvation limit, RAM port drive,
// memory-mapped I/O and a one-cycle read-return pipeline.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DBITS       = 16,
  parameter int ABITS       = 12,
  parameter int MAX_CPU_RUN = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req_i,
  input  logic             cpu_we_i,
  input  logic [DBITS-1:0] cpu_addr_i,
  input  logic [DBITS-1:0] cpu_wdata_i,
  output logic             cpu_gnt_o,
  output logic             cpu_rvalid_o,
  output logic [DBITS-1:0] cpu_rdata_o,
  input  logic             dma_req_i,
  input  logic             dma_we_i,
  input  logic [DBITS-1:0] dma_addr_i,
  input  logic [DBITS-1:0] dma_wdata_i,
  output logic             dma_gnt_o,
  output logic             dma_rvalid_o,
  output logic [DBITS-1:0] dma_rdata_o,
  output logic [ABITS-1:0] mem_addr_o,
  output logic             mem_we_o,
  output logic [DBITS-1:0] mem_din_o,
  input  logic [DBITS-1:0] mem_dout_i,
  input  logic [3:0]       key_i,
  input  logic [9:0]       sw_i,
  output logic [DBITS-1:0] hexout_o,
  output logic [9:0]       ledrout_o,
  output logic [7:0]       ledgout_o
);

  localparam int RUN_W = 4;

  logic             cpu_gnt, dma_gnt, acc;
  logic             g_we;
  logic [DBITS-1:0] g_addr, g_wdata;
  logic             is_ram;
  logic [DBITS-1:0] io_rdata;

  logic [RUN_W-1:0] run_q, run_d;
  rd_state_e        rd_q, rd_d;
  logic             rd_ram_q, rd_ram_d;
  logic [DBITS-1:0] io_rdata_q, io_rdata_d;
  logic [DBITS-1:0] cpu_hold_q, cpu_hold_d;
  logic [DBITS-1:0] dma_hold_q, dma_hold_d;
  logic [DBITS-1:0] rd_value;
  logic             cpu_rvalid, dma_rvalid;

  // Pick the winner for this cycle and route its transaction fields onto the shared path.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    // Grants are held off while reset is asserted so no transaction leaks out.
    if (rst_n) begin
      if (dma_req_i && (!cpu_req_i || run_q >= RUN_W'(MAX_CPU_RUN))) begin
        dma_gnt = 1'b1;
      end else if (cpu_req_i) begin
        cpu_gnt = 1'b1;
      end
    end
    acc     = cpu_gnt | dma_gnt;
    g_we    = dma_gnt ? dma_we_i    : cpu_we_i;
    g_addr  = dma_gnt ? dma_addr_i  : cpu_addr_i;
    g_wdata = dma_gnt ? dma_wdata_i : cpu_wdata_i;
  end

  // Count CPU wins against a waiting DMA; any DMA win or idle DMA restarts the run.
  always_comb begin
    run_d = run_q;
    if (!dma_req_i || dma_gnt) begin
      run_d = '0;
    end else if (cpu_gnt && run_q != '1) begin
      run_d = run_q + 1'b1;
    end
  end

  dmem_io_regs #(
    .DBITS (DBITS)
  ) u_io_regs (
    .clk      (clk),
    .rst_n    (rst_n),
    .acc_i    (acc),
    .we_i     (g_we),
    .addr_i   (g_addr),
    .wdata_i  (g_wdata),
    .key_i    (key_i),
    .sw_i     (sw_i),
    .is_ram_o (is_ram),
    .rdata_o  (io_rdata),
    .hex_o    (hexout_o),
    .ledr_o   (ledrout_o),
    .ledg_o   (ledgout_o)
  );

  assign cpu_gnt_o  = cpu_gnt;
  assign dma_gnt_o  = dma_gnt;
  assign mem_addr_o = g_addr[ABITS:1];
  assign mem_we_o   = acc & g_we & is_ram;
  assign mem_din_o  = g_wdata;

  // Read-return state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= IDLE;
    end else begin
      rd_q <= rd_d;
    end
  end

  // A read grant owns the return slot for exactly the next cycle.
  always_comb begin
    rd_d = IDLE;
    if (acc && !g_we) begin
      rd_d = dma_gnt ? RD_DMA : RD_CPU;
    end
  end

  // Return-slot outputs: RAM data arrives from the memory, I/O data was captured at grant.
  always_comb begin
    cpu_rvalid   = (rd_q == RD_CPU);
    dma_rvalid   = (rd_q == RD_DMA);
    rd_value     = rd_ram_q ? mem_dout_i : io_rdata_q;
    cpu_rvalid_o = cpu_rvalid;
    dma_rvalid_o = dma_rvalid;
    cpu_rdata_o  = cpu_rvalid ? rd_value : cpu_hold_q;
    dma_rdata_o  = dma_rvalid ? rd_value : dma_hold_q;
  end

  // Capture the source of a granted read and keep each requester's last returned word.
  always_comb begin
    rd_ram_d   = rd_ram_q;
    io_rdata_d = io_rdata_q;
    if (acc && !g_we) begin
      rd_ram_d   = is_ram;
      io_rdata_d = io_rdata;
    end
    cpu_hold_d = cpu_rvalid ? rd_value : cpu_hold_q;
    dma_hold_d = dma_rvalid ? rd_value : dma_hold_q;
  end

  // Run counter and read-return datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= '0;
      rd_ram_q   <= 1'b0;
      io_rdata_q <= '0;
      cpu_hold_q <= '0;
      dma_hold_q <= '0;
    end else begin
      run_q      <= run_d;
      rd_ram_q   <= rd_ram_d;
      io_rdata_q <= io_rdata_d;
      cpu_hold_q <= cpu_hold_d;
      dma_hold_q <= dma_hold_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios then randomized traffic, with an
// external synchronous RAM and a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int MAX_CPU_RUN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [15:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic        dma_req_i = 1'b0, dma_we_i = 1'b0;
  logic [15:0] dma_addr_i = '0, dma_wdata_i = '0;
  logic [3:0]  key_i = '0;
  logic [9:0]  sw_i = '0;
  logic        cpu_gnt_o, cpu_rvalid_o, dma_gnt_o, dma_rvalid_o, mem_we_o;
  logic [15:0] cpu_rdata_o, dma_rdata_o, mem_din_o, hexout_o;
  logic [15:0] mem_dout_i;
  logic [11:0] mem_addr_o;
  logic [9:0]  ledrout_o;
  logic [7:0]  ledgout_o;

  dmem_arbiter #(.DBITS(16), .ABITS(12), .MAX_CPU_RUN(MAX_CPU_RUN)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i), .dma_wdata_i(dma_wdata_i),
    .dma_gnt_o(dma_gnt_o), .dma_rvalid_o(dma_rvalid_o), .dma_rdata_o(dma_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i),
    .key_i(key_i), .sw_i(sw_i),
    .hexout_o(hexout_o), .ledrout_o(ledrout_o), .ledgout_o(ledgout_o)
  );

  always #5 clk = ~clk;

  // Physical RAM seen by the DUT: synchronous read, write-first.
  logic [15:0] ram [0:4095];
  always @(posedge clk) begin
    if (mem_we_o) ram[mem_addr_o] <= mem_din_o;
    mem_dout_i <= mem_we_o ? mem_din_o : ram[mem_addr_o];
  end

  int vectors = 0, miscompares = 0, cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [15:0] data; int due; } rd_exp_t;
  logic [15:0] model_mem [0:4095];
  logic [15:0] m_hex = '0;
  logic [9:0]  m_ledr = '0;
  logic [7:0]  m_ledg = '0;
  logic [15:0] last_cpu = '0, last_dma = '0;
  int          streak = 0;
  bit          exp_cpu_g = 0, exp_dma_g = 0;
  rd_exp_t     cpu_q[$], dma_q[$];
  rd_exp_t     e;
  logic [15:0] m_a, m_wd;
  logic        m_we, m_ram;

  function automatic logic [15:0] model_read(input logic [15:0] a);
    if (a[15:13] == 3'b000) return model_mem[a[12:1]];
    case (a)
      16'hFFF0: return {12'b0, key_i};
      16'hFFF2: return {6'b0, sw_i};
      16'hFFF8: return m_hex;
      16'hFFFA: return {6'b0, m_ledr};
      16'hFFFC: return {8'b0, m_ledg};
      default:  return 16'hDEAD;
    endcase
  endfunction

  // Monitor: mid-cycle comparison of grants, memory port, I/O outputs and read returns.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      cpu_q.delete(); dma_q.delete();
      streak = 0; m_hex = '0; m_ledr = '0; m_ledg = '0;
      last_cpu = '0; last_dma = '0; exp_cpu_g = 0; exp_dma_g = 0;
      check("rst_cpu_rvalid", cpu_rvalid_o, 0);
      check("rst_dma_rvalid", dma_rvalid_o, 0);
      check("rst_gnt", {cpu_gnt_o, dma_gnt_o}, 0);
      check("rst_mem_we", mem_we_o, 0);
    end else begin
      check("hexout", hexout_o, m_hex);
      check("ledrout", ledrout_o, m_ledr);
      check("ledgout", ledgout_o, m_ledg);
      // CPU return slot
      if (cpu_rvalid_o) begin
        if (cpu_q.size() == 0) check("cpu_rvalid_spurious", cpu_rvalid_o, 0);
        else begin
          e = cpu_q.pop_front();
          check("cpu_rdata", cpu_rdata_o, e.data);
          check("cpu_latency", cyc, e.due);
          last_cpu = e.data;
        end
      end else begin
        if (cpu_q.size() != 0 && cpu_q[0].due <= cyc) begin
          check("cpu_rvalid_missing", cpu_rvalid_o, 1);
          void'(cpu_q.pop_front());
        end
        check("cpu_rdata_hold", cpu_rdata_o, last_cpu);
      end
      // DMA return slot
      if (dma_rvalid_o) begin
        if (dma_q.size() == 0) check("dma_rvalid_spurious", dma_rvalid_o, 0);
        else begin
          e = dma_q.pop_front();
          check("dma_rdata", dma_rdata_o, e.data);
          check("dma_latency", cyc, e.due);
          last_dma = e.data;
        end
      end else begin
        if (dma_q.size() != 0 && dma_q[0].due <= cyc) begin
          check("dma_rvalid_missing", dma_rvalid_o, 1);
          void'(dma_q.pop_front());
        end
        check("dma_rdata_hold", dma_rdata_o, last_dma);
      end
      // Arbitration: CPU first unless DMA has watched MAX_CPU_RUN CPU wins in a row.
      exp_dma_g = dma_req_i && (!cpu_req_i || streak >= MAX_CPU_RUN);
      exp_cpu_g = cpu_req_i && !exp_dma_g;
      check("cpu_gnt", cpu_gnt_o, exp_cpu_g);
      check("dma_gnt", dma_gnt_o, exp_dma_g);
      if (exp_dma_g || !dma_req_i) streak = 0;
      else if (exp_cpu_g) streak++;
      if (exp_cpu_g || exp_dma_g) begin
        m_a   = exp_dma_g ? dma_addr_i : cpu_addr_i;
        m_wd  = exp_dma_g ? dma_wdata_i : cpu_wdata_i;
        m_we  = exp_dma_g ? dma_we_i : cpu_we_i;
        m_ram = (m_a < 16'h2000);
        check("mem_we", mem_we_o, m_we && m_ram);
        if (m_ram) check("mem_addr", mem_addr_o, m_a[12:1]);
        if (m_we) begin
          if (m_ram) begin
            check("mem_din", mem_din_o, m_wd);
            model_mem[m_a[12:1]] = m_wd;
          end else if (m_a == 16'hFFF8) m_hex = m_wd;
          else if (m_a == 16'hFFFA) m_ledr = m_wd[9:0];
          else if (m_a == 16'hFFFC) m_ledg = m_wd[7:0];
        end else begin
          e.data = model_read(m_a);
          e.due  = cyc + 1;
          if (exp_dma_g) dma_q.push_back(e); else cpu_q.push_back(e);
        end
      end else begin
        check("mem_we_idle", mem_we_o, 0);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Ends the current cycle; a request granted in it is withdrawn.
  task automatic tick();
    @(posedge clk); #1;
    if (exp_cpu_g) cpu_req_i = 1'b0;
    if (exp_dma_g) dma_req_i = 1'b0;
  endtask

  task automatic issue_cpu(input logic we, input logic [15:0] a, input logic [15:0] d);
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
  endtask

  task automatic issue_dma(input logic we, input logic [15:0] a, input logic [15:0] d);
    dma_req_i = 1'b1; dma_we_i = we; dma_addr_i = a; dma_wdata_i = d;
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [15:0] d);
    issue_cpu(we, a, d);
    for (int i = 0; i < 64 && cpu_req_i; i++) tick();
    if (cpu_req_i) begin
      check("cpu_gnt_timeout", cpu_req_i, 0);
      cpu_req_i = 1'b0;
    end
  endtask

  task automatic dma_op(input logic we, input logic [15:0] a, input logic [15:0] d);
    issue_dma(we, a, d);
    for (int i = 0; i < 64 && dma_req_i; i++) tick();
    if (dma_req_i) begin
      check("dma_gnt_timeout", dma_req_i, 0);
      dma_req_i = 1'b0;
    end
  endtask

  // Both requesters kept busy; records {cpu_gnt,dma_gnt} per cycle, oldest in the MSBs.
  task automatic run_both(input int n, output logic [19:0] seq);
    seq = '0;
    for (int i = 0; i < n; i++) begin
      if (!cpu_req_i) issue_cpu(1'b0, 16'h0010, 16'h0);
      if (!dma_req_i) issue_dma(1'b0, 16'h0020, 16'h0);
      @(negedge clk);
      seq = {seq[17:0], cpu_gnt_o, dma_gnt_o};
      tick();
    end
  endtask

  function automatic logic [15:0] rand_addr();
    logic [15:0] spots [8];
    spots = '{16'hFFF0, 16'hFFF2, 16'hFFF8, 16'hFFFA, 16'hFFFC, 16'h4000, 16'hFFF4, 16'h2000};
    case ($urandom_range(0, 3))
      0, 1:    return 16'($urandom_range(0, 31));
      2:       return spots[$urandom_range(0, 7)];
      default: return 16'($urandom_range(16'h1FF0, 16'h1FFF));
    endcase
  endfunction

  logic [19:0] seq;
  logic [15:0] v;

  initial begin
    for (int i = 0; i < 4096; i++) begin
      v = 16'($urandom);
      ram[i] = v;
      model_mem[i] = v;
    end
    ram[12'h100] = 16'h1234;
    model_mem[12'h100] = 16'h1234;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst_cpu_gnt", cpu_gnt_o, 0);
    check("rst_cpu_rdata", cpu_rdata_o, 0);
    check("rst_dma_rdata", dma_rdata_o, 0);
    check("rst_hex", hexout_o, 0);
    check("rst_ledr", ledrout_o, 0);
    check("rst_ledg", ledgout_o, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // CPU RAM read: grant in cycle 0, data in cycle 1
    cpu_op(1'b0, 16'h0200, 16'h0);
    check("t1_cpu_rvalid", cpu_rvalid_o, 1);
    check("t1_dma_rvalid", dma_rvalid_o, 0);
    tick();
    check("t1_rdata", cpu_rdata_o, 16'h1234);

    // HEX write/readback, KEY write ignored, KEY read
    cpu_op(1'b1, 16'hFFF8, 16'h00AB);
    check("t2_hex", hexout_o, 16'h00AB);
    cpu_op(1'b0, 16'hFFF8, 16'h0);
    tick();
    check("t2_hex_rd", cpu_rdata_o, 16'h00AB);
    key_i = 4'b1010;
    cpu_op(1'b1, 16'hFFF0, 16'h5555);
    cpu_op(1'b0, 16'hFFF0, 16'h0);
    tick();
    check("t2_key_rd", cpu_rdata_o, 16'h000A);

    // Continuous contention: C,C,C,C,D,C,C,C,C,D
    tick();
    run_both(10, seq);
    check("t3_grant_seq", seq, 20'hAA6A9);
    cpu_req_i = 1'b0; dma_req_i = 1'b0;
    tick(); tick();

    // DMA-only back-to-back reads
    dma_op(1'b0, 16'h0000, 16'h0);
    dma_op(1'b0, 16'h0002, 16'h0);
    dma_op(1'b0, 16'h0004, 16'h0);
    dma_op(1'b0, 16'h0006, 16'h0);
    tick();
    check("t4_last_rdata", dma_rdata_o, model_mem[3]);

    // Unmapped address
    cpu_op(1'b0, 16'h4000, 16'h0);
    tick();
    check("t5_dead", cpu_rdata_o, 16'hDEAD);
    issue_cpu(1'b1, 16'h4000, 16'h1234);
    @(negedge clk);
    check("t5_mem_we", mem_we_o, 0);
    tick();

    // Reset in the return cycle of a DMA read
    cpu_op(1'b1, 16'hFFF8, 16'hBEEF);
    cpu_op(1'b1, 16'hFFFA, 16'h03FF);
    cpu_op(1'b1, 16'hFFFC, 16'h00A5);
    dma_op(1'b0, 16'h0008, 16'h0);
    rst_n = 1'b0; cpu_req_i = 1'b0; dma_req_i = 1'b0;
    #1;
    check("t6_dma_rvalid", dma_rvalid_o, 0);
    check("t6_dma_rdata", dma_rdata_o, 0);
    check("t6_hex", hexout_o, 0);
    check("t6_ledr", ledrout_o, 0);
    check("t6_ledg", ledgout_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset with a partial CPU run: the arbitration run must restart from zero
    run_both(2, seq);
    rst_n = 1'b0; cpu_req_i = 1'b0; dma_req_i = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_both(10, seq);
    check("t6_run_restart", seq, 20'hAA6A9);
    cpu_req_i = 1'b0; dma_req_i = 1'b0;
    tick();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      key_i = 4'($urandom);
      sw_i  = 10'($urandom);
      if (!cpu_req_i && $urandom_range(0, 2) != 0) issue_cpu(1'($urandom), rand_addr(), 16'($urandom));
      if (!dma_req_i && $urandom_range(0, 2) != 0) issue_dma(1'($urandom), rand_addr(), 16'($urandom));
      tick();
    end
    cpu_req_i = 1'b0; dma_req_i = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
